// File: rtl/ss_pmod_gpio.sv
// PMOD GPIO subsystem slot: APB register file, output drive/direction, synchronised
// input readback and sticky rising/falling edge capture feeding a level interrupt.
module ss_pmod_gpio #(
  parameter int          NUM_PINS    = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h5047_0001
) (
  input  logic                clk_in,
  input  logic                reset_int,
  input  logic                high_speed_clk,
  input  logic [31:0]         PADDR,
  input  logic                PENABLE,
  input  logic                PSEL,
  input  logic [31:0]         PWDATA,
  input  logic                PWRITE,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic                irq_3,
  input  logic                irq_en_3,
  input  logic [7:0]          ss_ctrl_3,
  input  logic [NUM_PINS-1:0] pmod_gpi,
  output logic [NUM_PINS-1:0] pmod_gpo,
  output logic [NUM_PINS-1:0] pmod_gpio_oe
);

  localparam logic [2:0] A_OUT     = 3'd0;
  localparam logic [2:0] A_OE      = 3'd1;
  localparam logic [2:0] A_IN      = 3'd2;
  localparam logic [2:0] A_RISE_EN = 3'd3;
  localparam logic [2:0] A_FALL_EN = 3'd4;
  localparam logic [2:0] A_STATUS  = 3'd5;
  localparam logic [2:0] A_ID      = 3'd6;
  localparam logic [2:0] A_BAD     = 3'd7;

  // APB handshake: a transfer is the single access-phase cycle (PSEL & PENABLE);
  // the slave never stalls, so PREADY simply mirrors that cycle.
  logic       acc;
  logic       wr;
  logic       en;
  logic [2:0] addr;

  assign acc  = PSEL & PENABLE;
  assign wr   = acc & PWRITE;
  assign en   = ss_ctrl_3[0];
  assign addr = PADDR[4:2];

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;
  logic [NUM_PINS-1:0] in_q;
  logic [NUM_PINS-1:0] prev_q;
  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] oe_q, oe_d;
  logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
  logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
  logic [NUM_PINS-1:0] status_q, status_d;
  logic [NUM_PINS-1:0] rise, fall, set_mask;

  assign in_q     = sync_q[SYNC_STAGES-1];
  assign rise     = in_q & ~prev_q;
  assign fall     = ~in_q & prev_q;
  assign set_mask = (rise & rise_en_q) | (fall & fall_en_q);

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    if (wr) begin
      case (addr)
        A_OUT:     out_d     = PWDATA[NUM_PINS-1:0];
        A_OE:      oe_d      = PWDATA[NUM_PINS-1:0];
        A_RISE_EN: rise_en_d = PWDATA[NUM_PINS-1:0];
        A_FALL_EN: fall_en_d = PWDATA[NUM_PINS-1:0];
        A_STATUS:  status_d  = status_q & ~PWDATA[NUM_PINS-1:0];
        default:   ;
      endcase
    end
    // A capture on the same edge as a W1C must not be lost.
    if (en) status_d = status_d | set_mask;
  end

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      sync_q    <= '0;
      prev_q    <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pmod_gpi};
      prev_q    <= in_q;
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
    end
  end

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (addr)
      A_OUT:     rd_val[NUM_PINS-1:0] = out_q;
      A_OE:      rd_val[NUM_PINS-1:0] = oe_q;
      A_IN:      rd_val[NUM_PINS-1:0] = in_q;
      A_RISE_EN: rd_val[NUM_PINS-1:0] = rise_en_q;
      A_FALL_EN: rd_val[NUM_PINS-1:0] = fall_en_q;
      A_STATUS:  rd_val[NUM_PINS-1:0] = status_q;
      A_ID:      rd_val               = ID_VALUE;
      default:   rd_val               = '0;
    endcase
  end

  assign PRDATA       = (acc & ~PWRITE) ? rd_val : 32'h0;
  assign PREADY       = acc;
  assign PSLVERR      = acc & (addr == A_BAD);
  assign irq_3        = irq_en_3 & en & (|status_q);
  assign pmod_gpo     = en ? out_q : '0;
  assign pmod_gpio_oe = en ? oe_q  : '0;

  logic unused_bits;
  assign unused_bits = ^{high_speed_clk, PADDR[31:5], PADDR[1:0], PWDATA, ss_ctrl_3[7:1]};

endmodule

// File: tb/tb_ss_pmod_gpio.sv
// Directed bench for ss_pmod_gpio: a 16-pin and an 8-pin instance on a shared APB bus,
// expected read/pin values queued by the stimulus and checked by a separate monitor.
module tb_ss_pmod_gpio;
  localparam int N  = 16;
  localparam int N8 = 8;
  localparam int W  = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [31:0]   paddr = '0;
  logic          penable = 1'b0;
  logic          psel16 = 1'b0;
  logic          psel8 = 1'b0;
  logic [31:0]   pwdata = '0;
  logic          pwrite = 1'b0;
  logic          irq_en = 1'b1;
  logic [7:0]    ss_ctrl = 8'h01;
  logic [N-1:0]  gpi = '0;
  logic [N8-1:0] gpi8 = '0;

  logic [31:0]   prdata16, prdata8;
  logic          pready16, pready8, pslverr16, pslverr8, irq16, irq8;
  logic [N-1:0]  gpo16, oe16;
  logic [N8-1:0] gpo8, oe8;

  ss_pmod_gpio #(.NUM_PINS(N), .SYNC_STAGES(2), .ID_VALUE(32'h5047_0001)) u_dut (
    .clk_in(clk), .reset_int(rst), .high_speed_clk(1'b0),
    .PADDR(paddr), .PENABLE(penable), .PSEL(psel16), .PWDATA(pwdata), .PWRITE(pwrite),
    .PRDATA(prdata16), .PREADY(pready16), .PSLVERR(pslverr16),
    .irq_3(irq16), .irq_en_3(irq_en), .ss_ctrl_3(ss_ctrl),
    .pmod_gpi(gpi), .pmod_gpo(gpo16), .pmod_gpio_oe(oe16)
  );

  ss_pmod_gpio #(.NUM_PINS(N8), .SYNC_STAGES(2), .ID_VALUE(32'h5047_0001)) u_dut8 (
    .clk_in(clk), .reset_int(rst), .high_speed_clk(1'b0),
    .PADDR(paddr), .PENABLE(penable), .PSEL(psel8), .PWDATA(pwdata), .PWRITE(pwrite),
    .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8),
    .irq_3(irq8), .irq_en_3(irq_en), .ss_ctrl_3(ss_ctrl),
    .pmod_gpi(gpi8), .pmod_gpo(gpo8), .pmod_gpio_oe(oe8)
  );

  // Scoreboard queues: APB reads {pslverr, pready, prdata}; pin probes {0, gpo, oe, irq}.
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] pexp_q[$];
  string        pname_q[$];
  logic         probe_req = 1'b0;
  int           checks = 0;
  int           errors = 0;

  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    string        nm;
    if ((psel16 | psel8) && penable && !pwrite) begin
      act = psel8 ? {pslverr8, pready8, prdata8} : {pslverr16, pready16, prdata16};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read actual=%h", act);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL %s actual=%h expected=%h", nm, act, e);
        end
      end
    end
    if (probe_req) begin
      act = {1'b0, gpo16, oe16, irq16};
      checks++;
      if (pexp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_probe actual=%h", act);
      end else begin
        e  = pexp_q.pop_front();
        nm = pname_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL %s actual=%h expected=%h", nm, act, e);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input bit to8, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel16 = !to8; psel8 = to8; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel16 = 1'b0; psel8 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input bit to8, input logic [31:0] a, input logic [31:0] d,
                          input bit err, input string nm);
    exp_q.push_back({err, 1'b1, d});
    name_q.push_back(nm);
    @(posedge clk); #1;
    psel16 = !to8; psel8 = to8; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel16 = 1'b0; psel8 = 1'b0; penable = 1'b0;
  endtask

  task automatic check_pins(input logic [N-1:0] g, input logic [N-1:0] o, input logic irq,
                            input string nm);
    pexp_q.push_back({1'b0, g, o, irq});
    pname_q.push_back(nm);
    probe_req = 1'b1;
    @(negedge clk); #1;
    probe_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and register map defaults
    wait_cycles(3);
    check_pins('0, '0, 1'b0, "reset_pins");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apb_read(1'b0, 32'(i * 4), (i == 6) ? 32'h5047_0001 : 32'h0, (i == 7),
               $sformatf("rd_off_%0h", i * 4));
    end

    // Output drive, then subsystem disable forcing
    apb_write(1'b0, 32'h00, 32'h0000_A5A5);
    apb_write(1'b0, 32'h04, 32'h0000_00FF);
    check_pins(16'hA5A5, 16'h00FF, 1'b0, "drive_en");
    ss_ctrl = 8'h00;
    check_pins('0, '0, 1'b0, "drive_dis");
    apb_read(1'b0, 32'h00, 32'h0000_A5A5, 1'b0, "out_held_dis");
    ss_ctrl = 8'hFE;
    check_pins('0, '0, 1'b0, "en_bit0_only");
    ss_ctrl = 8'h01;

    // Rising edge capture and latency
    apb_write(1'b0, 32'h0C, 32'h0000_0001);
    gpi[0] = 1'b1;
    wait_cycles(2);
    check_pins(16'hA5A5, 16'h00FF, 1'b0, "irq_before_capture");
    wait_cycles(1);
    check_pins(16'hA5A5, 16'h00FF, 1'b1, "irq_at_capture");
    apb_read(1'b0, 32'h08, 32'h0000_0001, 1'b0, "in_high");
    apb_read(1'b0, 32'h14, 32'h0000_0001, 1'b0, "status_rise");
    apb_write(1'b0, 32'h14, 32'h0000_0001);
    apb_read(1'b0, 32'h14, 32'h0, 1'b0, "status_w1c");
    check_pins(16'hA5A5, 16'h00FF, 1'b0, "irq_cleared");
    gpi[0] = 1'b0;
    wait_cycles(5);
    apb_read(1'b0, 32'h14, 32'h0, 1'b0, "no_fall_flag");
    apb_read(1'b0, 32'h08, 32'h0, 1'b0, "in_low");

    // W1C on the same edge as a new capture: set wins
    gpi[0] = 1'b1;
    apb_write(1'b0, 32'h14, 32'h0000_0001);
    apb_read(1'b0, 32'h14, 32'h0000_0001, 1'b0, "set_wins");
    check_pins(16'hA5A5, 16'h00FF, 1'b1, "irq_set_wins");
    apb_write(1'b0, 32'h14, 32'h0000_0001);
    apb_read(1'b0, 32'h14, 32'h0, 1'b0, "late_w1c");
    check_pins(16'hA5A5, 16'h00FF, 1'b0, "irq_late_w1c");

    // Width masking, error slot, RO writes and aliasing
    apb_write(1'b1, 32'h00, 32'hFFFF_FFFF);
    apb_read(1'b1, 32'h00, 32'h0000_00FF, 1'b0, "out_mask8");
    apb_read(1'b1, 32'h1C, 32'h0, 1'b1, "bad_off8");
    apb_write(1'b0, 32'h1C, 32'h0000_0000);
    apb_write(1'b0, 32'h18, 32'h0000_0000);
    apb_read(1'b0, 32'h18, 32'h5047_0001, 1'b0, "id_ro");
    apb_read(1'b0, 32'hFFFF_FFE3, 32'h0000_A5A5, 1'b0, "alias_out");
    apb_write(1'b0, 32'h10, 32'hFFFF_FFFF);
    apb_read(1'b0, 32'h10, 32'h0000_FFFF, 1'b0, "fall_en_mask16");

    // Reset during an APB write
    gpi[0] = 1'b0;
    wait_cycles(4);
    gpi[0] = 1'b1;
    wait_cycles(4);
    check_pins(16'hA5A5, 16'h00FF, 1'b1, "irq_pre_reset");
    @(posedge clk); #1;
    psel16 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h0000_1234;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    psel16 = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
    check_pins('0, '0, 1'b0, "pins_after_reset");
    apb_read(1'b0, 32'h00, 32'h0, 1'b0, "out_after_reset");
    apb_read(1'b0, 32'h14, 32'h0, 1'b0, "status_after_reset");
    wait_cycles(4);
    apb_read(1'b0, 32'h14, 32'h0, 1'b0, "no_spurious_flag");
    apb_read(1'b0, 32'h08, 32'h0000_0001, 1'b0, "in_after_reset");

    wait_cycles(2);
    if (exp_q.size() != 0 || pexp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected reads=%0d probes=%0d required=0", exp_q.size(), pexp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
